// File: rtl/count_monitor.sv
// Checker for the bounded (sn, i) step counter: verifies step, permission and
// relation invariants each cycle, keeps per-run statistics and a sticky error code.
module count_monitor #(
  parameter int LIMIT = 70,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         selector,
  input  logic [W-1:0] sn_in,
  input  logic [W-1:0] i_in,
  output logic         done,
  output logic         err,
  output logic [2:0]   err_code,
  output logic [15:0]  adv_cnt,
  output logic [31:0]  acc_sum,
  output logic [7:0]   run_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t         state, state_n;
  logic           sel_q;
  logic [W-1:0]   prev_sn, prev_i;
  logic [W-1:0]   dsn, di;
  logic           start, step0, step1, perm;
  logic [2:0]     viol;
  logic [2:0]     code_n;
  logic [15:0]    adv_n;
  logic [31:0]    acc_n;
  logic [7:0]     run_n;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign start = (sn_in == '0) && (i_in == W'(1));
  assign dsn   = sn_in - prev_sn;
  assign di    = i_in - prev_i;
  assign step0 = (dsn == '0) && (di == '0);
  assign step1 = (dsn == W'(1)) && (di == W'(1));
  assign perm  = sel_q && (prev_i <= W'(LIMIT));

  // Lowest-numbered violation wins
  always_comb begin
    viol = 3'd0;
    if (!step0 && !step1)                                 viol = 3'd1;
    else if (step1 && !perm)                              viol = 3'd2;
    else if (step0 && perm)                               viol = 3'd3;
    else if (sn_in != i_in - W'(1))                       viol = 3'd4;
    else if ((i_in > W'(LIMIT)) && (sn_in != W'(LIMIT)))  viol = 3'd5;
  end

  always_comb begin
    state_n = state;
    code_n  = err_code;
    adv_n   = adv_cnt;
    acc_n   = acc_sum;
    run_n   = run_cnt;
    if (clr) begin
      state_n = IDLE;
      code_n  = 3'd0;
      adv_n   = 16'd0;
      acc_n   = 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_n = RUN;
          adv_n   = 16'd0;
          acc_n   = 32'd0;
        end
        RUN: begin
          if (start) begin
            adv_n = 16'd0;
            acc_n = 32'd0;
          end else if (viol != 3'd0) begin
            state_n = ERR;
            code_n  = viol;
          end else begin
            if (step1) begin
              adv_n = adv_cnt + 16'd1;
              acc_n = sat_add(acc_sum, sn_in);
            end
            if (i_in == W'(LIMIT + 1)) begin
              state_n = DONE;
              run_n   = run_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_n = RUN;
            adv_n   = 16'd0;
            acc_n   = 32'd0;
          end else if ((sn_in != prev_sn) || (i_in != prev_i)) begin
            state_n = ERR;
            code_n  = 3'd2;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample stage: counter history plus registered state and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 1'b0;
      prev_sn  <= '0;
      prev_i   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
      adv_cnt  <= 16'd0;
      acc_sum  <= 32'd0;
      run_cnt  <= 8'd0;
    end else begin
      state    <= state_n;
      sel_q    <= selector;
      prev_sn  <= sn_in;
      prev_i   <= i_in;
      done     <= (state_n == DONE);
      err      <= (state_n == ERR);
      err_code <= code_n;
      adv_cnt  <= adv_n;
      acc_sum  <= acc_n;
      run_cnt  <= run_n;
    end
  end

endmodule
